buffer_read_serializer: RTL and testbench
=========================================

BUFFER_READ_SERIALIZER -- requirements
Module: buffer_read_serializer

Interface
REQ-001 The block SHALL have parameter ROW_SIZE, default 8: bit width of one buffer element.
REQ-002 The block SHALL have parameter PAR_READ, default 4: elements delivered per buffer read.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port buf_empty, input, 1 bit: buffer has fewer than PAR_READ valid elements.
REQ-006 The block SHALL have port buf_dout, input, ROW_SIZE*PAR_READ bits: combinational buffer read data at the current read pointer.
REQ-007 The block SHALL have port update_read_pointer, output, 1 bit: one-cycle pulse advancing the buffer read pointer by PAR_READ.
REQ-008 The block SHALL have port dout, output, ROW_SIZE bits: current output element.
REQ-009 The block SHALL have port dout_valid, output, 1 bit: dout holds a valid element.
REQ-010 The block SHALL have port dout_ready, input, 1 bit: downstream accepts dout this cycle.
REQ-011 The block SHALL have port elem_idx, output, $clog2(PAR_READ) bits (minimum 1): index of the element on dout within the loaded word.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no word held) and SEND (word held, elements pending).
REQ-013 In IDLE with buf_empty=0, the block SHALL assert update_read_pointer combinationally, capture buf_dout into an internal word register on that clock edge, clear elem_idx to 0, and enter SEND.
REQ-014 In IDLE with buf_empty=1, the block SHALL hold update_read_pointer=0 and remain in IDLE.
REQ-015 In SEND, the block SHALL drive dout_valid=1 and dout=element elem_idx of the held word; element k is bits [k*ROW_SIZE +: ROW_SIZE].
REQ-016 A transfer SHALL occur when dout_valid=1 and dout_ready=1 in the same cycle; without a transfer, dout, elem_idx and dout_valid SHALL hold.
REQ-017 On a transfer with elem_idx < PAR_READ-1, elem_idx SHALL increment by 1.
REQ-018 On a transfer with elem_idx = PAR_READ-1 and buf_empty=0, the block SHALL pulse update_read_pointer, load buf_dout, reset elem_idx to 0, and stay in SEND (no bubble cycle).
REQ-019 On a transfer with elem_idx = PAR_READ-1 and buf_empty=1, the block SHALL return to IDLE with dout_valid=0 on the next cycle.
REQ-020 update_read_pointer SHALL be asserted only in the cycles defined in REQ-013 and REQ-018, for exactly one cycle per word loaded, and never while rst=1.
REQ-021 Latency from buf_empty falling (in IDLE) to dout_valid=1 SHALL be one clock cycle.
REQ-022 With PAR_READ=1, every transfer SHALL be a last-element transfer.

Reset
REQ-023 While rst=1 at a clock edge, state SHALL become IDLE, elem_idx 0, word register 0, dout 0, dout_valid 0.
REQ-024 Reset asserted mid-word SHALL discard the remaining elements without advancing the read pointer.

Configuration
REQ-025 With macro BUF_READER_MSB_FIRST_EN defined, dout SHALL present element PAR_READ-1-elem_idx (most significant element first); elem_idx semantics and handshake are unchanged.
REQ-026 Without BUF_READER_MSB_FIRST_EN, dout SHALL present element elem_idx (least significant element first).

Verification
REQ-027 Reset, buf_empty=1 for 10 cycles -> update_read_pointer=0 and dout_valid=0 throughout.
REQ-028 buf_dout=32'h44332211, buf_empty=0 for one cycle then 1, dout_ready=1 -> one update_read_pointer pulse; dout 8'h11, 8'h22, 8'h33, 8'h44 on four consecutive cycles; dout_valid=0 afterwards.
REQ-029 Same word, dout_ready=0 for 3 cycles while dout=8'h22 -> dout holds 8'h22, elem_idx holds 1, no pulse.
REQ-030 Two words 32'h44332211 then 32'h88776655, buf_empty=0 throughout, ready=1 -> eight consecutive valid elements 11..88 with no bubble, exactly two pulses.
REQ-031 rst=1 after two elements transferred -> next cycle dout_valid=0, dout=0, no pulse; 8'h33 and 8'h44 never appear.
REQ-032 BUF_READER_MSB_FIRST_EN defined, word 32'h44332211 -> dout sequence 8'h44, 8'h33, 8'h22, 8'h11.

Source files
------------

// File: rtl/buffer_read_serializer.sv
// buffer_read_serializer
// Reads PAR_READ elements of ROW_SIZE bits from a buffer in one word and
// presents them one at a time on a valid/ready output stream. A new word
// is fetched back-to-back with the last element so a steady buffer gives
// an unbroken element stream.
//
// Optional build macro: BUF_READER_MSB_FIRST_EN
//   defined   -> most significant element of each word is sent first
//   undefined -> least significant element is sent first (default)
module buffer_read_serializer #(
  parameter int ROW_SIZE = 8,
  parameter int PAR_READ = 4,
  localparam int IDX_W   = (PAR_READ > 1) ? $clog2(PAR_READ) : 1,
  localparam int WORD_W  = ROW_SIZE * PAR_READ
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                buf_empty,
  input  logic [WORD_W-1:0]   buf_dout,
  output logic                update_read_pointer,
  output logic [ROW_SIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [IDX_W-1:0]    elem_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [WORD_W-1:0]   word_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic                vld_p0;
  logic                xfer;
  logic                last_elem;

  // Selects the element shown on dout for a given position in the word.
  function automatic logic [ROW_SIZE-1:0] pick_elem(
    input logic [WORD_W-1:0] w,
    input logic [IDX_W-1:0]  idx
  );
    int sel;
`ifdef BUF_READER_MSB_FIRST_EN
    sel = PAR_READ - 1 - int'(idx);
`else
    sel = int'(idx);
`endif
    return w[sel*ROW_SIZE +: ROW_SIZE];
  endfunction

  assign vld_p0    = (state_q == SEND);
  assign xfer      = vld_p0 && dout_ready;
  assign last_elem = (idx_p0 == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave IDLE when a word is available, return to IDLE
  // only when the last element goes out and nothing is waiting behind it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!buf_empty) state_d = SEND;
      SEND: if (xfer && last_elem && buf_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the read-pointer pulse doubles as the word-load strobe
  // and is suppressed during reset so a reset never consumes buffer data.
  always_comb begin
    update_read_pointer = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    update_read_pointer = !buf_empty;
        SEND:    update_read_pointer = xfer && last_elem && !buf_empty;
        default: update_read_pointer = 1'b0;
      endcase
    end
    dout_valid = vld_p0;
    dout       = pick_elem(word_p0, idx_p0);
    elem_idx   = idx_p0;
  end

  // ---- stage p0: held word and element position ----
  // Word register and index: load on pointer pulse, step on mid-word
  // transfers, otherwise hold. Reset clears both so dout reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_p0 <= '0;
      idx_p0  <= '0;
    end else if (update_read_pointer) begin
      word_p0 <= buf_dout;
      idx_p0  <= '0;
    end else if (xfer && !last_elem) begin
      idx_p0  <= idx_p0 + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_buffer_read_serializer.sv
// Directed bench for buffer_read_serializer (ROW_SIZE=8, PAR_READ=4).
// Expected element orders follow BUF_READER_MSB_FIRST_EN when defined.
module tb_buffer_read_serializer;

  logic        clk;
  logic        rst;
  logic        buf_empty;
  logic [31:0] buf_dout;
  logic        update_read_pointer;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [1:0]  elem_idx;

  int passed;
  int total;
  int pulses;

  logic [7:0] el_a [4];
  logic [7:0] el_b [4];

  buffer_read_serializer #(
    .ROW_SIZE(8),
    .PAR_READ(4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .buf_empty           (buf_empty),
    .buf_dout            (buf_dout),
    .update_read_pointer (update_read_pointer),
    .dout                (dout),
    .dout_valid          (dout_valid),
    .dout_ready          (dout_ready),
    .elem_idx            (elem_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    pulses = 0;
`ifdef BUF_READER_MSB_FIRST_EN
    el_a = '{8'h44, 8'h33, 8'h22, 8'h11};
    el_b = '{8'h88, 8'h77, 8'h66, 8'h55};
`else
    el_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    el_b = '{8'h55, 8'h66, 8'h77, 8'h88};
`endif

    // Reset with data available: no pulse may escape.
    rst = 1'b1; buf_empty = 1'b0; dout_ready = 1'b0; buf_dout = 32'h44332211;
    #1 chk("upd_during_rst0", {31'b0, update_read_pointer}, 32'd0);
    cyc();
    cyc();
    chk("upd_during_rst1", {31'b0, update_read_pointer}, 32'd0);
    chk("rst_valid", {31'b0, dout_valid}, 32'd0);
    chk("rst_dout", {24'b0, dout}, 32'd0);
    chk("rst_idx", {30'b0, elem_idx}, 32'd0);

    // Empty buffer for 10 cycles.
    rst = 1'b0; buf_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_upd", {31'b0, update_read_pointer}, 32'd0);
      chk("idle_valid", {31'b0, dout_valid}, 32'd0);
      cyc();
    end

    // Single word, ready always high.
    buf_empty = 1'b0; dout_ready = 1'b1;
    #1 chk("w1_pulse", {31'b0, update_read_pointer}, 32'd1);
    chk("w1_valid_pre", {31'b0, dout_valid}, 32'd0);
    cyc();
    buf_empty = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("w1_valid", {31'b0, dout_valid}, 32'd1);
      chk("w1_dout", {24'b0, dout}, {24'b0, el_a[k]});
      chk("w1_idx", {30'b0, elem_idx}, k);
      chk("w1_upd", {31'b0, update_read_pointer}, 32'd0);
      cyc();
    end
    #1 chk("w1_valid_after", {31'b0, dout_valid}, 32'd0);
    chk("w1_upd_after", {31'b0, update_read_pointer}, 32'd0);
    cyc();

    // Backpressure on the second element.
    buf_empty = 1'b0;
    #1 chk("bp_pulse", {31'b0, update_read_pointer}, 32'd1);
    cyc();
    buf_empty = 1'b1;
    #1 chk("bp_dout0", {24'b0, dout}, {24'b0, el_a[0]});
    cyc();
    dout_ready = 1'b0; buf_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_dout", {24'b0, dout}, {24'b0, el_a[1]});
      chk("bp_hold_idx", {30'b0, elem_idx}, 32'd1);
      chk("bp_hold_valid", {31'b0, dout_valid}, 32'd1);
      chk("bp_hold_upd", {31'b0, update_read_pointer}, 32'd0);
      cyc();
    end
    dout_ready = 1'b1; buf_empty = 1'b1;
    #1 chk("bp_dout1", {24'b0, dout}, {24'b0, el_a[1]});
    cyc();
    #1 chk("bp_dout2", {24'b0, dout}, {24'b0, el_a[2]});
    cyc();
    #1 chk("bp_dout3", {24'b0, dout}, {24'b0, el_a[3]});
    chk("bp_upd3", {31'b0, update_read_pointer}, 32'd0);
    cyc();
    #1 chk("bp_valid_after", {31'b0, dout_valid}, 32'd0);
    cyc();

    // Two words back to back, no bubble.
    buf_dout = 32'h44332211; buf_empty = 1'b0;
    #1 chk("b2b_pulse0", {31'b0, update_read_pointer}, 32'd1);
    if (update_read_pointer) pulses++;
    cyc();
    buf_dout = 32'h88776655;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("b2b_a_valid", {31'b0, dout_valid}, 32'd1);
      chk("b2b_a_dout", {24'b0, dout}, {24'b0, el_a[k]});
      chk("b2b_a_upd", {31'b0, update_read_pointer}, (k == 3) ? 32'd1 : 32'd0);
      if (update_read_pointer) pulses++;
      cyc();
    end
    buf_empty = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("b2b_b_valid", {31'b0, dout_valid}, 32'd1);
      chk("b2b_b_dout", {24'b0, dout}, {24'b0, el_b[k]});
      chk("b2b_b_upd", {31'b0, update_read_pointer}, 32'd0);
      if (update_read_pointer) pulses++;
      cyc();
    end
    #1 chk("b2b_valid_after", {31'b0, dout_valid}, 32'd0);
    chk("b2b_pulses", pulses, 32'd2);
    cyc();

    // Reset in the middle of a word.
    buf_dout = 32'h44332211; buf_empty = 1'b0;
    #1 chk("mid_pulse", {31'b0, update_read_pointer}, 32'd1);
    cyc();
    buf_empty = 1'b1;
    #1 chk("mid_dout0", {24'b0, dout}, {24'b0, el_a[0]});
    cyc();
    #1 chk("mid_dout1", {24'b0, dout}, {24'b0, el_a[1]});
    cyc();
    rst = 1'b1; buf_empty = 1'b0;
    #1 chk("mid_rst_upd", {31'b0, update_read_pointer}, 32'd0);
    cyc();
    rst = 1'b0; buf_empty = 1'b1;
    #1 chk("mid_valid", {31'b0, dout_valid}, 32'd0);
    chk("mid_dout", {24'b0, dout}, 32'd0);
    chk("mid_idx", {30'b0, elem_idx}, 32'd0);
    chk("mid_upd", {31'b0, update_read_pointer}, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_after_valid", {31'b0, dout_valid}, 32'd0);
      chk("mid_after_dout", {24'b0, dout}, 32'd0);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
